ext_mem_responder: RTL

External data-memory target for the MIPS datapath. It serves every access the address decoder routes off-chip (CS=1, i.e. ADDR outside 0x4B00–0x4EFF) using a 4-phase REQ/ACK handshake with a programmable number of wait states. It holds a DEPTH-word backing store and returns read data with ACK. BUSY tells the pipeline to stall while a transaction is open.

---
 rtl/ext_mem_pkg.sv | 18 +
 rtl/ext_mem_array.sv | 35 +++
 rtl/ext_mem_responder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ext_mem_pkg.sv
// Shared constants for the external data-memory responder.
// FSM encoding plus the internal address window used to build external addresses.
package ext_mem_pkg;

  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_ACKED = 2'd2;

  localparam logic [31:0] INT_LO = 32'h0000_4B00;
  localparam logic [31:0] INT_HI = 32'h0000_4F00;

  function automatic logic is_ext(input logic [31:0] a);
    return (a < INT_LO) || (a >= INT_HI);
  endfunction

endpackage

// File: rtl/ext_mem_array.sv
// Single-port backing RAM with write-first registered read port.
// Only the read register is reset; the storage itself keeps its contents.
module ext_mem_array
  import ext_mem_pkg::*;
#(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = DATA_W_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i && we_i) mem_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (en_i) begin
      rdata_q <= we_i ? wdata_i : mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ext_mem_responder.sv
// Off-chip data-memory target: 4-phase REQ/ACK with programmable wait states.
// The RAM is touched only on the edge that enters ACKED, so aborts never write.
module ext_mem_responder
  import ext_mem_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned DATA_W      = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              CS,
  input  logic              REQ,
  input  logic              WE,
  input  logic [31:0]       ADDR,
  input  logic [DATA_W-1:0] WDATA,
  output logic [DATA_W-1:0] RDATA,
  output logic              ACK,
  output logic              BUSY
);

  localparam int unsigned CW =
    (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic                 we_q, we_d;
  logic [DATA_W-1:0]    wd_q, wd_d;
  logic                 ack_q, busy_q;

  logic                 ram_en, ram_we;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [DATA_W-1:0]    ram_wd;

  logic unused_addr;
  assign unused_addr = ^{ADDR[31:ADDR_BITS+2], ADDR[1:0]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    we_d     = we_q;
    wd_d     = wd_q;
    ram_en   = 1'b0;
    ram_we   = we_q;
    ram_addr = idx_q;
    ram_wd   = wd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (REQ && CS) begin
          idx_d = ADDR[ADDR_BITS+1:2];
          we_d  = WE;
          wd_d  = WDATA;
          cnt_d = CW'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            // No wait: the acceptance edge is also the ACKED entry edge
            state_d  = ST_ACKED;
            ram_en   = 1'b1;
            ram_we   = WE;
            ram_addr = ADDR[ADDR_BITS+1:2];
            ram_wd   = WDATA;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!REQ) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = ST_ACKED;
            ram_en  = 1'b1;
          end
        end
      end
      ST_ACKED: begin
        if (!REQ) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wd_q    <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      ack_q   <= (state_d == ST_ACKED);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  ext_mem_array #(
    .AW(ADDR_BITS),
    .DW(DATA_W)
  ) u_array (
    .clk_i  (CLK),
    .rst_ni (RST_n),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(ram_wd),
    .rdata_o(RDATA)
  );

  assign ACK  = ack_q;
  assign BUSY = busy_q;

endmodule
